imem_loader: RTL and testbench

- Writer side of the instruction-memory interface: receives a byte stream (program image), assembles 32-bit little-endian words and writes them into instruction memory through a write port.
- The core reads instruction memory; this block fills it.
- Sits between a byte source (UART receiver or test harness) and the instruction memory write port.
- Holds the core in reset (cpu_rst) until a complete, checksum-verified image has been written.

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Fills instruction memory from a byte stream and keeps the core in reset
//   until a complete, checksum-verified program image has been written.
//
//   Frame: 4 length bytes N (word count, LSB first), 4*N payload bytes
//   (each word LSB first), then 1 checksum byte = XOR of all payload bytes.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx_data    incoming byte
//   rx_valid   rx_data is valid
//   rx_ready   loader accepts a byte this cycle (transfer on valid && ready)
//   mem_we     one-cycle instruction-memory write strobe
//   mem_addr   word-aligned byte address of the write
//   mem_wdata  word to write
//   cpu_rst    core reset, held high until the image is loaded and verified
//   done       image loaded and verified (terminal until rst)
//   err        image rejected: oversize or checksum mismatch (terminal)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH_WORDS = 64,
    parameter logic [WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_rst,
    output logic             done,
    output logic             err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             r_state;
    logic [31:0]        r_len;
    logic [1:0]         r_byte_cnt;
    logic [IDX_W-1:0]   r_word_idx;
    logic [7:0]         r_csum;
    logic [31:0]        r_asm;
    logic               r_mem_we;
    logic [WIDTH-1:0]   r_mem_addr;
    logic [WIDTH-1:0]   r_mem_wdata;

    logic               w_accept;
    logic [31:0]        w_len_full;
    logic [31:0]        w_word;
    logic               w_last_word;
    logic [WIDTH-1:0]   w_word_addr;

    assign rx_ready = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept = rx_valid && rx_ready;

    // Complete length / word as they will look once the current byte lands,
    // so the decision on the 4th byte needs no extra cycle.
    assign w_len_full  = {rx_data, r_len[23:0]};
    assign w_word      = {rx_data, r_asm[23:0]};
    assign w_last_word = ({{(32-IDX_W){1'b0}}, r_word_idx} == (r_len - 32'd1));
    assign w_word_addr = BASE_ADDR + (WIDTH'(r_word_idx) << 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LEN;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_word_idx  <= '0;
            r_csum      <= '0;
            r_asm       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= '0;
        end else begin
            // Strobe is a single-cycle pulse; address/data hold between writes.
            r_mem_we <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_accept) begin
                        r_len[8*r_byte_cnt +: 8] <= rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            // Full 32-bit compare: any nonzero high byte rejects.
                            if (w_len_full > 32'(DEPTH_WORDS))
                                r_state <= S_ERR;
                            else if (w_len_full == 32'd0)
                                r_state <= S_CSUM;
                            else
                                r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_asm[8*r_byte_cnt +: 8] <= rx_data;
                        r_csum     <= r_csum ^ rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                            r_mem_wdata <= WIDTH'(w_word);
                            r_word_idx  <= r_word_idx + 1'b1;
                            if (w_last_word)
                                r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_accept)
                        r_state <= (rx_data == r_csum) ? S_DONE : S_ERR;
                end
                S_DONE:  r_state <= S_DONE;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERR);
    assign cpu_rst   = (r_state != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a per-cycle vector table for the
// nominal and bad-checksum frames, plus directed multi-cycle sequences.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    imem_loader #(.WIDTH(32), .DEPTH_WORDS(64), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc;

    always @(posedge clk) cyc++;

    // Write monitor: records every strobe and the edge count it appeared after.
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
    end

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        crst;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic r, input logic v, input logic [7:0] d,
                        input logic rdy, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic crst,
                        input logic dn, input logic er);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.rdy = rdy; t.we = we; t.addr = a;
        t.wdata = wd; t.crst = crst; t.dn = dn; t.er = er;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        wa_q = {}; wd_q = {}; wc_q = {};
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        if (gap) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        last_acc = cyc;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send(w[8*k +: 8], gap);
    endtask

    logic [31:0] tmp;
    logic [7:0]  csum;
    int          acc4[$];

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

        // ---------------- table: nominal then bad checksum ----------------
        addv(1,0,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h01, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h13, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h50, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,1,32'h0,32'h00500013, 1,0,0);
        addv(0,1,8'h43, 0,0,32'h0,32'h00500013, 0,1,0);
        addv(0,1,8'h55, 0,0,32'h0,32'h00500013, 0,1,0);
        addv(0,0,8'h00, 0,0,32'h0,32'h00500013, 0,1,0);
        addv(1,0,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h01, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,0,8'h77, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h13, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h50, 1,0,32'h0,32'h0,        1,0,0);
        addv(0,1,8'h00, 1,1,32'h0,32'h00500013, 1,0,0);
        addv(0,1,8'h44, 0,0,32'h0,32'h00500013, 1,0,1);
        addv(0,1,8'h43, 0,0,32'h0,32'h00500013, 1,0,1);
        addv(0,1,8'h00, 0,0,32'h0,32'h00500013, 1,0,1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; rx_valid = vecs[i].v; rx_data = vecs[i].d;
            @(posedge clk); #1;
            checks++;
            if ({rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err} !==
                {vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].crst, vecs[i].dn, vecs[i].er}) begin
                errors++;
                $display("FAIL vec%0d: got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b expected rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b",
                         i, rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err,
                         vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                         vecs[i].crst, vecs[i].dn, vecs[i].er);
            end
            $display("vec %0d: rst=%b v=%b d=%h -> rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b",
                     i, vecs[i].rst, vecs[i].v, vecs[i].d, rx_ready, mem_we,
                     mem_addr, mem_wdata, cpu_rst, done, err);
        end

        // ---------------- N=3 back-to-back, valid held high ----------------
        do_reset();
        send_word(32'd3, 0);
        acc4 = {};
        send_word(32'h11111111, 0); acc4.push_back(last_acc);
        send_word(32'h22222222, 0); acc4.push_back(last_acc);
        send_word(32'h33333333, 0); acc4.push_back(last_acc);
        send(8'h00, 0);
        idle(2);
        chk("multi_nwrites", wa_q.size(), 3);
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            chk($sformatf("multi_addr%0d", i), wa_q[i], 32'(4*i));
            chk($sformatf("multi_data%0d", i), wd_q[i], 32'h11111111 * (i+1));
            chk($sformatf("multi_lat%0d", i), wc_q[i], acc4[i]);
        end
        chk("multi_done", {done, err, cpu_rst}, 3'b100);
        $display("multi-word: writes=%0d done=%b err=%b", wa_q.size(), done, err);

        // ---------------- oversize N=65 ----------------
        do_reset();
        send_word(32'd65, 0);
        chk("over65_err", {err, done, rx_ready, cpu_rst}, 4'b1001);
        idle(3);
        chk("over65_nowrite", wa_q.size(), 0);
        $display("oversize 65: err=%b writes=%0d", err, wa_q.size());

        // nonzero high length byte
        do_reset();
        send_word(32'h01000001, 0);
        chk("hibyte_err", {err, done}, 2'b10);
        idle(1);
        $display("high length byte: err=%b", err);

        // ---------------- N=64 full capacity ----------------
        do_reset();
        send_word(32'd64, 0);
        csum = 8'h00;
        for (int i = 0; i < 64; i++) begin
            tmp = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            for (int k = 0; k < 4; k++) csum ^= tmp[8*k +: 8];
            send_word(tmp, 0);
        end
        send(csum, 0);
        idle(2);
        chk("full_nwrites", wa_q.size(), 64);
        if (wa_q.size() == 64) begin
            chk("full_last_addr", wa_q[63], 32'h000000FC);
            chk("full_last_data", wd_q[63], 32'hFFFEFDFC);
        end
        chk("full_done", {done, err, cpu_rst}, 3'b100);
        $display("full 64: writes=%0d done=%b", wa_q.size(), done);

        // ---------------- zero length ----------------
        do_reset();
        send_word(32'd0, 0);
        send(8'h00, 0);
        idle(2);
        chk("zero_done", {done, err, cpu_rst}, 3'b100);
        chk("zero_nowrite", wa_q.size(), 0);
        $display("zero length csum 00: done=%b writes=%0d", done, wa_q.size());

        do_reset();
        send_word(32'd0, 0);
        send(8'h01, 0);
        idle(1);
        chk("zero_badcsum", {done, err, cpu_rst}, 3'b011);
        $display("zero length csum 01: err=%b", err);

        // ---------------- reset mid-load, then gapped nominal ----------------
        do_reset();
        send_word(32'd2, 0);
        send_word(32'hAABBCCDD, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        chk("mid_prewrites", wa_q.size(), 1);
        do_reset();
        chk("mid_reset", {rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err},
            {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
        send_word(32'd1, 1);
        send_word(32'h00500013, 1);
        tmp = 32'(last_acc);
        send(8'h43, 1);
        idle(2);
        chk("mid_nwrites", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            chk("mid_addr", wa_q[0], 32'h0);
            chk("mid_data", wd_q[0], 32'h00500013);
            chk("mid_lat", wc_q[0], tmp);
        end
        chk("mid_done", {done, err, cpu_rst}, 3'b100);
        $display("reset mid-load + gapped: writes=%0d done=%b", wa_q.size(), done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
